// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver (data width, parity, stop bits) with input synchroniser and error flags.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around mid-bit instead of a single sample.
module uart_rx_cfg #(
   parameter int CLK_PER_BIT = 100,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 parity_err,
   output logic                 frame_err
);
   localparam int CW   = $clog2(CLK_PER_BIT);
   localparam int HALF = CLK_PER_BIT / 2;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;
   state_t state, state_n;
   logic rx_m, rx_s, rx_p;
   logic [CW-1:0] cnt;
   logic [3:0] idx;
   logic [DATA_BITS-1:0] sh;
   logic par_f, frm_f, samp, samp_en, fall, bit_end, last_stop;
   assign fall      = rx_p & ~rx_s;
   assign bit_end   = cnt == CW'(CLK_PER_BIT - 1);
   assign last_stop = state == STOP && samp_en && idx == 4'(STOP_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
   logic maj_a, maj_b;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         maj_a <= 1'b1;
         maj_b <= 1'b1;
      end else begin
         if (cnt == CW'(HALF - 1)) maj_a <= rx_s;
         if (cnt == CW'(HALF)) maj_b <= rx_s;
      end
   assign samp_en = cnt == CW'(HALF + 1);
   assign samp    = (maj_a & maj_b) | (maj_a & rx_s) | (maj_b & rx_s);
`else
   assign samp_en = cnt == CW'(HALF);
   assign samp    = rx_s;
`endif
   always_comb begin
      state_n = state;
      case (state)
         IDLE:       state_n = fall ? START : IDLE;
         START:      state_n = (samp_en && samp) ? IDLE : bit_end ? DATA : START;
         DATA:       state_n = !(bit_end && idx == 4'(DATA_BITS - 1)) ? DATA : (PARITY != 0) ? PARITY_BIT : STOP;
         PARITY_BIT: state_n = bit_end ? STOP : PARITY_BIT;
         STOP:       state_n = last_stop ? IDLE : STOP;
         default:    state_n = IDLE;
      endcase
   end
   // Completion returns to IDLE mid-stop-bit so the next start edge is caught with no gap.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         {rx_m, rx_s, rx_p} <= 3'b111;
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         sh         <= '0;
         par_f      <= 1'b0;
         frm_f      <= 1'b0;
         rx_ready   <= 1'b0;
         rx_data    <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_m     <= rx;
         rx_s     <= rx_m;
         rx_p     <= rx_s;
         state    <= state_n;
         cnt      <= (state == IDLE || state_n == IDLE || bit_end) ? '0 : cnt + 1'b1;
         idx      <= (state_n != state) ? '0 : bit_end ? idx + 1'b1 : idx;
         rx_ready <= last_stop;
         if (state == IDLE && fall) begin
            par_f <= 1'b0;
            frm_f <= 1'b0;
         end
         if (state == DATA && samp_en) sh <= {samp, sh[DATA_BITS-1:1]};
         if (state == PARITY_BIT && samp_en) par_f <= samp ^ (^sh) ^ (PARITY == 1);
         if (state == STOP && samp_en) frm_f <= frm_f | ~samp;
         if (last_stop) begin
            rx_data    <= sh;
            parity_err <= par_f;
            frame_err  <= frm_f | ~samp;
         end
      end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg, one instance 8E1 and one 8N2, both at 16 clocks per bit.
module tb_uart_rx_cfg;
   localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
   localparam bit MAJ = 1'b1;
`else
   localparam bit MAJ = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rx2 = 1'b1;
   logic rx_ready, parity_err, frame_err, rx_ready2, parity_err2, frame_err2;
   logic [7:0] rx_data, rx_data2;
   logic [9:0] exp_q[$], obs_q[$], exp2_q[$], obs2_q[$];
   int total = 0, passed = 0;

   uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut (
      .clk(clk), .rst(rst), .rx(rx), .rx_ready(rx_ready), .rx_data(rx_data),
      .parity_err(parity_err), .frame_err(frame_err));
   uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .rx(rx2), .rx_ready(rx_ready2), .rx_data(rx_data2),
      .parity_err(parity_err2), .frame_err(frame_err2));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_ready) obs_q.push_back({frame_err, parity_err, rx_data});
      if (rx_ready2) obs2_q.push_back({frame_err2, parity_err2, rx_data2});
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   task automatic set_line(input bit sel, input logic v);
      if (sel) rx2 = v;
      else rx = v;
   endtask

   // A glitch at bit offset 9 lands on the receiver's mid-bit sample after the synchroniser delay.
   task automatic drive_bit(input bit sel, input logic b, input bit g);
      for (int i = 0; i < CPB; i++) begin
         set_line(sel, (g && i == 9) ? ~b : b);
         @(posedge clk); #1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n * CPB) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input bit bad_par, input bit stop_low, input int rst_bit);
      if (rst_bit < 0) begin
         if (sel) exp2_q.push_back({stop_low, 1'b0, d});
         else exp_q.push_back({stop_low, bad_par, d});
      end
      drive_bit(sel, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == rst_bit) rst = 1'b1;
         drive_bit(sel, d[i], MAJ);
      end
      if (!sel) drive_bit(sel, (^d) ^ bad_par, 1'b0);
      drive_bit(sel, ~stop_low, 1'b0);
      if (sel) drive_bit(sel, 1'b1, 1'b0);
      set_line(sel, 1'b1);
      if (rst_bit >= 0) rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total += 4;
      if (rx_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", rx_ready); else passed++;
      if (rx_data !== 8'h00) $display("FAIL reset_data got %h want 00", rx_data); else passed++;
      if (parity_err !== 1'b0) $display("FAIL reset_perr got %b want 0", parity_err); else passed++;
      if (frame_err !== 1'b0) $display("FAIL reset_ferr got %b want 0", frame_err); else passed++;
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_good();
      logic [9:0] e, o;
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, -1);
      idle(2);
      total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL good_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) $display("FAIL good_frame got %h want %h", o, e); else passed++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_parity();
      logic [9:0] e, o;
      send_frame(1'b0, 8'hA3, 1'b1, 1'b0, -1);
      idle(1);
      total++;
      if (parity_err !== 1'b1) $display("FAIL parity_held got %b want 1", parity_err); else passed++;
      send_frame(1'b0, 8'h12, 1'b0, 1'b0, -1);
      idle(2);
      total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL parity_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) $display("FAIL parity_frame got %h want %h", o, e); else passed++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_framing();
      logic [9:0] e, o;
      send_frame(1'b0, 8'h0F, 1'b0, 1'b1, -1);
      idle(2);
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, -1);
      idle(2);
      total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL frame_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) $display("FAIL frame_frame got %h want %h", o, e); else passed++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_glitch();
      logic [9:0] e, o;
      rx = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rx = 1'b1;
      idle(2);
      total++;
      if (obs_q.size() != 0) $display("FAIL glitch_pulse got %0d want 0", obs_q.size()); else passed++;
      obs_q.delete();
      send_frame(1'b0, 8'h81, 1'b0, 1'b0, -1);
      idle(2);
      total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL glitch_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) $display("FAIL glitch_frame got %h want %h", o, e); else passed++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_mid_reset();
      logic [9:0] e, o;
      send_frame(1'b0, 8'hC6, 1'b0, 1'b0, 4);
      idle(1);
      total += 4;
      if (obs_q.size() != 0) $display("FAIL mrst_pulse got %0d want 0", obs_q.size()); else passed++;
      if (rx_data !== 8'h00) $display("FAIL mrst_data got %h want 00", rx_data); else passed++;
      if (parity_err !== 1'b0) $display("FAIL mrst_perr got %b want 0", parity_err); else passed++;
      if (frame_err !== 1'b0) $display("FAIL mrst_ferr got %b want 0", frame_err); else passed++;
      obs_q.delete();
      send_frame(1'b0, 8'h7E, 1'b0, 1'b0, -1);
      idle(2);
      total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL mrst_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) $display("FAIL mrst_frame got %h want %h", o, e); else passed++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [9:0] e, o;
      fork
         for (int v = 0; v < 256; v++) send_frame(1'b0, 8'(v), 1'b0, 1'b0, -1);
         for (int v = 0; v < 256; v++) send_frame(1'b1, 8'(v), 1'b0, 1'b0, -1);
      join
      idle(2);
      total += 2;
      if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
      if (obs2_q.size() != exp2_q.size()) $display("FAIL b2b_n2_count got %0d want %0d", obs2_q.size(), exp2_q.size()); else passed++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
         if (o !== e) $display("FAIL b2b_frame got %h want %h", o, e); else passed++;
      end
      while (exp2_q.size() > 0 && obs2_q.size() > 0) begin
         e = exp2_q.pop_front(); o = obs2_q.pop_front(); total++;
         if (o !== e) $display("FAIL b2b_n2_frame got %h want %h", o, e); else passed++;
      end
      exp_q.delete(); obs_q.delete(); exp2_q.delete(); obs2_q.delete();
   endtask

   initial begin
      test_reset();
      test_good();
      test_parity();
      test_framing();
      test_glitch();
      test_mid_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
